// File: rtl/vend_pkg.sv
// Shared definitions for the vending path: coin values, restock codes,
// FSM states and the coin encoding used by both the vend FSM and the
// change dispenser.
package vend_pkg;

  // Coin values in nickel units
  localparam int unsigned VAL_N = 1;
  localparam int unsigned VAL_D = 2;
  localparam int unsigned VAL_Q = 5;

  // restock_coin encodings
  localparam logic [1:0] RESTOCK_N    = 2'b00;
  localparam logic [1:0] RESTOCK_D    = 2'b01;
  localparam logic [1:0] RESTOCK_Q    = 2'b10;
  localparam logic [1:0] RESTOCK_NONE = 2'b11;

  // Coin encoding matches restock_coin so one value indexes the inventory
  typedef enum logic [1:0] {
    COIN_N    = RESTOCK_N,
    COIN_D    = RESTOCK_D,
    COIN_Q    = RESTOCK_Q,
    COIN_NONE = RESTOCK_NONE
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Value of a coin in nickel units; COIN_NONE is worth nothing
  function automatic logic [2:0] coin_value(input coin_t c);
    logic [2:0] v;
    v = 3'd0;
    case (c)
      COIN_Q:  v = 3'(VAL_Q);
      COIN_D:  v = 3'(VAL_D);
      COIN_N:  v = 3'(VAL_N);
      default: v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counter: saturating increment on restock,
// decrement on eject, simultaneous inc/dec cancels out.
module coin_inventory #(
  parameter int CNT_W = 6,
  parameter int INIT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [CNT_W-1:0] count_reg;

  // Counter update: reload on reset, saturate at both ends
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= CNT_W'(INIT);
    end else if (inc && !dec && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end else if (dec && !inc && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: accepts an amount in nickel units, ejects
// quarters, dimes and nickels one at a time through an ack handshake,
// and reports any amount it could not return.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W  = 4,
  parameter int CNT_W  = 6,
  parameter int INIT_Q = 10,
  parameter int INIT_D = 10,
  parameter int INIT_N = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  input  logic             eject_ack,
  input  logic             restock_valid,
  input  logic [1:0]       restock_coin,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] shortfall,
  output logic             empty_q,
  output logic             empty_d,
  output logic             empty_n
);

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] rem_reg, rem_next;
  coin_t            coin_reg, coin_next;

  // Inventory indexed by coin encoding: 0 nickel, 1 dime, 2 quarter
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       inc;
  logic [2:0]       dec;
  logic [2:0]       empty;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_inv
      localparam int INIT = (gi == 2) ? INIT_Q : ((gi == 1) ? INIT_D : INIT_N);

      assign inc[gi] = restock_valid && (restock_coin == 2'(gi));
      assign dec[gi] = (state_reg == ST_EJECT) && eject_ack && (coin_reg == coin_t'(2'(gi)));

      coin_inventory #(
        .CNT_W (CNT_W),
        .INIT  (INIT)
      ) u_inv (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[gi]),
        .dec   (dec[gi]),
        .count (cnt[gi]),
        .empty (empty[gi])
      );
    end
  endgenerate

  // State, remaining amount and chosen coin registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      rem_reg   <= '0;
      coin_reg  <= COIN_NONE;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      coin_reg  <= coin_next;
    end
  end

  // Next-state logic: greedy coin selection and ack-driven bookkeeping
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    coin_next  = coin_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          rem_next   = req_amt;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if ((rem_reg >= AMT_W'(VAL_Q)) && (cnt[COIN_Q] != '0)) begin
          coin_next  = COIN_Q;
          state_next = ST_EJECT;
        end else if ((rem_reg >= AMT_W'(VAL_D)) && (cnt[COIN_D] != '0)) begin
          coin_next  = COIN_D;
          state_next = ST_EJECT;
        end else if ((rem_reg >= AMT_W'(VAL_N)) && (cnt[COIN_N] != '0)) begin
          coin_next  = COIN_N;
          state_next = ST_EJECT;
        end else begin
          coin_next  = COIN_NONE;
          state_next = ST_DONE;
        end
      end
      ST_EJECT: begin
        if (eject_ack) begin
          rem_next   = rem_reg - AMT_W'(coin_value(coin_reg));
          state_next = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only
  assign req_ready = (state_reg == ST_IDLE);
  assign eject_q   = (state_reg == ST_EJECT) && (coin_reg == COIN_Q);
  assign eject_d   = (state_reg == ST_EJECT) && (coin_reg == COIN_D);
  assign eject_n   = (state_reg == ST_EJECT) && (coin_reg == COIN_N);
  assign done      = (state_reg == ST_DONE);
  assign short     = done && (rem_reg != '0);
  assign shortfall = done ? rem_reg : '0;
  assign empty_q   = empty[COIN_Q];
  assign empty_d   = empty[COIN_D];
  assign empty_n   = empty[COIN_N];

endmodule
